// File: rtl/i2c_init_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : utils (package)
// Description : Shared types for the I2C init sequencer: ROM entry layout,
//               opcode encoding and sequencer FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package utils;

    // Opcode field of an init ROM entry; any other value is illegal
    typedef enum logic [7:0] {
        OP_WRITE = 8'h00,
        OP_DELAY = 8'h01,
        OP_END   = 8'hFF
    } init_op_e;

    // 32-bit ROM entry; bit 16 (rsvd) carries no meaning
    typedef struct packed {
        init_op_e    op;
        logic [6:0]  dev;
        logic        rsvd;
        logic [7:0]  reg_addr;
        logic [7:0]  data;
    } init_entry_t;

    // Sequencer states
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_LATCH     = 4'd2,
        ST_DECODE    = 4'd3,
        ST_ISSUE     = 4'd4,
        ST_WAIT_DONE = 4'd5,
        ST_DELAY     = 4'd6,
        ST_FINISH    = 4'd7,
        ST_FAIL      = 4'd8
    } init_state_e;

endpackage
`default_nettype wire

// File: rtl/i2c_init_seq_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : Free-running divider; emits a one-cycle pulse every
//               DELAY_TICKS enabled cycles. Synchronous clear restarts the
//               count so the first unit after entry is a full one.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int DELAY_TICKS = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int c_CNT_W = (DELAY_TICKS > 1) ? $clog2(DELAY_TICKS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DELAY_TICKS - 1);

    logic [c_CNT_W-1:0] r_cnt;

    // Unit counter: 0..DELAY_TICKS-1 while enabled, cleared on request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_tick = i_en && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/i2c_init_seq.sv
`default_nettype none
// ============================================================================
// Module      : i2c_init_seq
// Description : Walks the init ROM and issues one register write per WRITE
//               entry to the I2C byte master; executes DELAY entries, retries
//               NACKed writes and reports done / sticky error.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_init_seq
    import utils::*;
#(
    parameter int LINES       = 16,
    parameter int DELAY_TICKS = 100000,
    parameter int MAX_RETRY   = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [$clog2(LINES)-1:0] err_index,
    output logic [$clog2(LINES)-1:0] rom_addr,
    input  logic [31:0]              rom_data,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [6:0]               cmd_dev,
    output logic [7:0]               cmd_reg,
    output logic [7:0]               cmd_data,
    input  logic                     cmd_done,
    input  logic                     cmd_nack
);

    localparam int c_AW = $clog2(LINES);
    localparam int c_RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [c_AW-1:0] c_LAST_IDX  = c_AW'(LINES - 1);
    localparam logic [c_RW-1:0] c_MAX_RETRY = c_RW'(MAX_RETRY);

    init_state_e     r_state;
    init_state_e     w_state_nxt;
    init_state_e     w_adv_state;
    init_entry_t     w_entry;
    logic [c_AW-1:0] r_ptr;
    logic [c_AW-1:0] r_rom_addr;
    logic [c_AW-1:0] r_err_index;
    logic [c_RW-1:0] r_retry;
    logic [7:0]      r_dly_cnt;
    logic [6:0]      r_dev;
    logic [7:0]      r_reg;
    logic [7:0]      r_data;
    logic            r_err;
    logic            w_advance;
    logic            w_retry_ok;
    logic            w_tick;
    logic            w_unused_rsvd;

    assign w_entry       = init_entry_t'(rom_data);
    assign w_unused_rsvd = w_entry.rsvd;
    assign w_retry_ok    = (r_retry < c_MAX_RETRY);
    // The pointer saturates: the last line finishes the run instead of wrapping
    assign w_adv_state   = (r_ptr == c_LAST_IDX) ? ST_FINISH : ST_FETCH;

    tick_gen #(
        .DELAY_TICKS (DELAY_TICKS)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (r_state == ST_DELAY),
        .i_clr  ((r_state != ST_DELAY) && (w_state_nxt == ST_DELAY)),
        .o_tick (w_tick)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and pointer-advance strobe
    always_comb begin
        w_state_nxt = r_state;
        w_advance   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_FETCH;
            end
            ST_FETCH:  w_state_nxt = ST_LATCH;
            ST_LATCH:  w_state_nxt = ST_DECODE;
            ST_DECODE: begin
                case (w_entry.op)
                    OP_WRITE: w_state_nxt = ST_ISSUE;
                    OP_DELAY: begin
                        if (w_entry.data == 8'd0) begin
                            w_advance   = 1'b1;
                            w_state_nxt = w_adv_state;
                        end else begin
                            w_state_nxt = ST_DELAY;
                        end
                    end
                    OP_END:   w_state_nxt = ST_FINISH;
                    default:  w_state_nxt = ST_FAIL;
                endcase
            end
            ST_ISSUE: begin
                // cmd_done is not looked at here, so a stray one is ignored
                if (cmd_ready) w_state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (cmd_done) begin
                    if (!cmd_nack) begin
                        w_advance   = 1'b1;
                        w_state_nxt = w_adv_state;
                    end else if (w_retry_ok) begin
                        w_state_nxt = ST_ISSUE;
                    end else begin
                        w_state_nxt = ST_FAIL;
                    end
                end
            end
            ST_DELAY: begin
                if (w_tick && (r_dly_cnt == 8'd1)) begin
                    w_advance   = 1'b1;
                    w_state_nxt = w_adv_state;
                end
            end
            ST_FINISH: w_state_nxt = ST_IDLE;
            ST_FAIL:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: pointer, ROM address, command fields, retry/delay counters, error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_rom_addr  <= '0;
            r_err_index <= '0;
            r_retry     <= '0;
            r_dly_cnt   <= '0;
            r_dev       <= '0;
            r_reg       <= '0;
            r_data      <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_err   <= 1'b0;
                        r_ptr   <= '0;
                        r_retry <= '0;
                    end
                end
                ST_FETCH: r_rom_addr <= r_ptr;
                ST_DECODE: begin
                    // Command fields only move while cmd_valid is low
                    if (w_entry.op == OP_WRITE) begin
                        r_dev  <= w_entry.dev;
                        r_reg  <= w_entry.reg_addr;
                        r_data <= w_entry.data;
                    end
                    r_dly_cnt <= w_entry.data;
                end
                ST_WAIT_DONE: begin
                    if (cmd_done && cmd_nack && w_retry_ok) r_retry <= r_retry + 1'b1;
                end
                ST_DELAY: begin
                    if (w_tick) r_dly_cnt <= r_dly_cnt - 8'd1;
                end
                ST_FAIL: begin
                    r_err       <= 1'b1;
                    r_err_index <= r_ptr;
                end
                default: ;
            endcase
            if (w_advance) begin
                r_retry <= '0;
                if (r_ptr != c_LAST_IDX) r_ptr <= r_ptr + 1'b1;
            end
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_FINISH);
    assign cmd_valid = (r_state == ST_ISSUE);
    assign err       = r_err;
    assign err_index = r_err_index;
    assign rom_addr  = r_rom_addr;
    assign cmd_dev   = r_dev;
    assign cmd_reg   = r_reg;
    assign cmd_data  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_i2c_init_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_init_seq
// Description : Directed self-checking bench for i2c_init_seq with a
//               synchronous ROM model and a simple I2C master model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_init_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy, done, err, cmd_valid;
    logic [3:0]  err_index, rom_addr;
    logic [31:0] rom_data;
    logic        cmd_ready, cmd_done, cmd_nack;
    logic [6:0]  cmd_dev;
    logic [7:0]  cmd_reg, cmd_data;

    always #5 clk = ~clk;

    i2c_init_seq #(
        .LINES       (16),
        .DELAY_TICKS (10),
        .MAX_RETRY   (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_index (err_index),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dev   (cmd_dev),
        .cmd_reg   (cmd_reg),
        .cmd_data  (cmd_data),
        .cmd_done  (cmd_done),
        .cmd_nack  (cmd_nack)
    );

    // ROM model: one cycle read latency
    logic [31:0] rom_mem [16];
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    // Master model state
    int          pend      = 0;
    int          nack_left = 0;
    logic [7:0]  nack_reg  = 8'h00;
    bit          slow      = 1'b0;
    bit          stray     = 1'b0;
    int          hs_cnt    = 0;
    logic [22:0] hs_log [64];

    // Master: logs handshakes, answers 3 cycles later, NACKs a chosen register
    initial begin
        cmd_ready = 1'b0;
        cmd_done  = 1'b0;
        cmd_nack  = 1'b0;
        forever begin
            @(negedge clk);
            cmd_done = 1'b0;
            cmd_nack = 1'b0;
            if (!rst_n) begin
                pend      = 0;
                cmd_ready = 1'b0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        cmd_done = 1'b1;
                        if (nack_left > 0 && cmd_reg == nack_reg) begin
                            cmd_nack = 1'b1;
                            nack_left--;
                        end
                    end
                end
                if (stray) begin
                    cmd_done = 1'b1;
                    stray    = 1'b0;
                end
                cmd_ready = slow ? ~cmd_ready : 1'b1;
                if (cmd_valid && cmd_ready) begin
                    if (hs_cnt < 64) hs_log[hs_cnt] = {cmd_dev, cmd_reg, cmd_data};
                    hs_cnt++;
                    pend = 3;
                end
            end
        end
    end

    int vectors     = 0;
    int miscompares = 0;
    int first_valid, done_cnt, done_at, max_addr, stab_viol;
    bit saw_valid, timed_out;
    logic err_k1;
    logic [34:0] snap;
    int restart_at = -1;
    int stray_at   = -1;
    int rst_at     = -1;

    localparam logic [31:0] c_END = 32'hFF00_0000;
    localparam logic [22:0] c_A   = {7'h27, 8'h41, 8'h10};
    localparam logic [22:0] c_B   = {7'h27, 8'h98, 8'h03};

    function automatic logic [31:0] wr(input logic [6:0] d, input logic [7:0] r, input logic [7:0] v);
        return {8'h00, d, 1'b0, r, v};
    endfunction

    function automatic logic [31:0] dly(input logic [7:0] n);
        return {8'h01, 16'h0000, n};
    endfunction

    task automatic fill_end();
        for (int i = 0; i < 16; i++) rom_mem[i] = c_END;
    endtask

    task automatic load_basic();
        fill_end();
        rom_mem[0] = wr(7'h27, 8'h41, 8'h10);
        rom_mem[1] = wr(7'h27, 8'h98, 8'h03);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One run: start pulse in cycle 0, FETCH is cycle 1; observe each cycle at negedge
    task automatic run(input int budget);
        int          k;
        logic        pv;
        logic [22:0] pf;
        first_valid = -1; done_cnt = 0; done_at = -1; max_addr = 0;
        stab_viol = 0; saw_valid = 0; timed_out = 0; hs_cnt = 0;
        pv = 1'b0; pf = '0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        forever begin
            if (k == rst_at) begin
                rst_n = 1'b0;
                #1;
                snap = {busy, done, err, cmd_valid, err_index, rom_addr, cmd_dev, cmd_reg, cmd_data};
                break;
            end
            if (k == 1) err_k1 = err;
            start = (k == restart_at);
            if (k == stray_at) stray = 1'b1;
            if (cmd_valid) begin
                saw_valid = 1'b1;
                if (first_valid < 0) first_valid = k;
                if (pv && pf != {cmd_dev, cmd_reg, cmd_data}) stab_viol++;
            end
            pv = cmd_valid;
            pf = {cmd_dev, cmd_reg, cmd_data};
            if (done) begin
                done_cnt++;
                done_at = k;
            end
            if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
            if (!busy) break;
            if (k >= budget) begin
                timed_out = 1'b1;
                break;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        fill_end();
        repeat (3) @(negedge clk);

        // Reset state
        check("reset status", {busy, done, err, cmd_valid, err_index, rom_addr}, 32'd0);
        check("reset cmd fields", {cmd_dev, cmd_reg, cmd_data}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Two writes then END; a start during the run must be ignored
        load_basic();
        restart_at = 6;
        run(300);
        restart_at = -1;
        check("basic timeout", timed_out, 0);
        check("basic first valid latency", first_valid, 4);
        check("basic handshakes", hs_cnt, 2);
        check("basic hs0 fields", hs_log[0], c_A);
        check("basic hs1 fields", hs_log[1], c_B);
        check("basic done pulses", done_cnt, 1);
        check("basic err", err, 0);
        check("basic busy end", busy, 0);
        check("basic field stability", stab_viol, 0);

        // DELAY 0 costs 3 cycles; DELAY 3 costs 3+30; END then FINISH:
        // FETCH=1 ... entry0 done at 3, entry1 DECODE 6, DELAY 7..36, END DECODE 39, FINISH 40
        fill_end();
        rom_mem[0] = dly(8'd0);
        rom_mem[1] = dly(8'd3);
        stray_at = 15;
        run(300);
        stray_at = -1;
        check("delay timeout", timed_out, 0);
        check("delay done cycle", done_at, 40);
        check("delay done pulses", done_cnt, 1);
        check("delay no cmd_valid", saw_valid, 0);
        check("delay err", err, 0);

        // First write NACKed twice, then ACKed; ready toggles
        load_basic();
        nack_reg  = 8'h41;
        nack_left = 2;
        slow      = 1'b1;
        run(300);
        slow = 1'b0;
        check("retry timeout", timed_out, 0);
        check("retry handshakes", hs_cnt, 4);
        check("retry hs0", hs_log[0], c_A);
        check("retry hs1", hs_log[1], c_A);
        check("retry hs2", hs_log[2], c_A);
        check("retry hs3", hs_log[3], c_B);
        check("retry done pulses", done_cnt, 1);
        check("retry err", err, 0);
        check("retry field stability", stab_viol, 0);

        // Entry 5 NACKed four times: 1 attempt + 3 retries, then error
        fill_end();
        for (int i = 0; i < 6; i++) rom_mem[i] = wr(7'h27, 8'(8'h10 + i), 8'(i));
        nack_reg  = 8'h15;
        nack_left = 4;
        run(400);
        check("fail timeout", timed_out, 0);
        check("fail err", err, 1);
        check("fail err_index", err_index, 5);
        check("fail done pulses", done_cnt, 0);
        check("fail handshakes", hs_cnt, 9);
        check("fail last hs", hs_log[8], {7'h27, 8'h15, 8'h05});
        check("fail busy end", busy, 0);

        // Next start clears err and the table now completes
        nack_left = 0;
        run(400);
        check("rerun err after start", err_k1, 0);
        check("rerun done pulses", done_cnt, 1);
        check("rerun err", err, 0);
        check("rerun handshakes", hs_cnt, 6);

        // Full table of writes, no END
        for (int i = 0; i < 16; i++) rom_mem[i] = wr(7'h27, 8'(i), 8'(8'hF0 ^ i));
        run(1000);
        check("full timeout", timed_out, 0);
        check("full handshakes", hs_cnt, 16);
        check("full done pulses", done_cnt, 1);
        check("full max rom_addr", max_addr, 15);
        check("full last hs", hs_log[15], {7'h27, 8'h0F, 8'hFF});
        check("full err", err, 0);

        // Illegal opcode at index 1
        fill_end();
        rom_mem[0] = wr(7'h27, 8'h41, 8'h10);
        rom_mem[1] = 32'h5A00_0000;
        run(300);
        check("illegal err", err, 1);
        check("illegal err_index", err_index, 1);
        check("illegal handshakes", hs_cnt, 1);
        check("illegal done pulses", done_cnt, 0);

        // Reset while in WAIT_DONE (cycles 5..7 of the basic table)
        load_basic();
        rst_at = 6;
        run(300);
        rst_at = -1;
        check("async reset outputs", snap, 35'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(300);
        check("post-reset first valid", first_valid, 4);
        check("post-reset handshakes", hs_cnt, 2);
        check("post-reset hs0", hs_log[0], c_A);
        check("post-reset done pulses", done_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
